// File: rtl/reflet_float_op_driver.sv
`default_nettype none
// ============================================================================
// Module      : reflet_float_op_driver
// Description : Drives a fixed-latency floating-point operator. Accepts an
//               operand pair, holds it on the operator inputs, waits the
//               operator latency, captures the result and presents it
//               downstream with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module reflet_float_op_driver #(
    parameter int float_size = 16,
    parameter int latency    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [float_size-1:0] op_a,
    input  logic [float_size-1:0] op_b,
    output logic [float_size-1:0] opr_a,
    output logic [float_size-1:0] opr_b,
    input  logic [float_size-1:0] opr_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [float_size-1:0] result,
    output logic                  busy
);

    // One extra bit so the counter can hold the value 'latency' itself.
    localparam int               CNT_W   = $clog2(latency) + 1;
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(latency);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [CNT_W-1:0]        counter_q,   counter_d;
    logic                    res_valid_q, res_valid_d;
    logic [float_size-1:0]   result_q,    result_d;
    logic [float_size-1:0]   opr_a_q,     opr_a_d;
    logic [float_size-1:0]   opr_b_q,     opr_b_d;

    // State, counter, operand and result registers with async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            opr_a_q     <= '0;
            opr_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
            opr_a_q     <= opr_a_d;
            opr_b_q     <= opr_b_d;
        end
    end

    // Next-state logic; enable low overrides everything and returns to IDLE.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        res_valid_d = res_valid_q;
        result_d    = result_q;
        opr_a_d     = opr_a_q;
        opr_b_d     = opr_b_q;

        if (!enable) begin
            // Operands and the last result are kept; only the control state
            // is abandoned.
            state_d     = ST_IDLE;
            counter_d   = '0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        opr_a_d   = op_a;
                        opr_b_d   = op_b;
                        counter_d = CNT_ONE;
                        state_d   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Counter stops at latency, so it can never wrap.
                    if (counter_q == LAT_CNT) begin
                        result_d    = opr_result;
                        res_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        counter_d = counter_q + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    // Consumption returns to IDLE; a new request can only be
                    // taken on the following edge.
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        counter_d   = '0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    counter_d   = '0;
                    res_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Handshake and status outputs decoded from the registered state.
    always_comb begin
        req_ready = (state_q == ST_IDLE) && enable;
        busy      = (state_q != ST_IDLE);
        res_valid = res_valid_q;
        result    = result_q;
        opr_a     = opr_a_q;
        opr_b     = opr_b_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_reflet_float_op_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_reflet_float_op_driver
// Description : Self-checking bench for reflet_float_op_driver. Two
//               instances: latency 2 (operator modelled as one pipeline
//               register) and latency 1 (combinational operator).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reflet_float_op_driver;

    localparam int LAT2 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] op_a, op_b;

    logic        req_valid2, req_ready2, res_valid2, res_ready2, busy2;
    logic [15:0] opr_a2, opr_b2, opr_result2, result2;
    logic        req_valid1, req_ready1, res_valid1, res_ready1, busy1;
    logic [15:0] opr_a1, opr_b1, opr_result1, result1;

    int vectors    = 0;
    int miscompares = 0;

    // Reference operator function (chosen so 3C00 op 4000 = 4200).
    function automatic logic [15:0] f_op(input logic [15:0] a, input logic [15:0] b);
        return 16'(a + b - 16'h3A00);
    endfunction

    // Latency-2 operator: one register stage after the operand registers.
    logic [15:0] pipe2;
    always @(posedge clk) pipe2 <= f_op(opr_a2, opr_b2);
    assign opr_result2 = pipe2;
    // Latency-1 operator: purely combinational.
    assign opr_result1 = f_op(opr_a1, opr_b1);

    always #5 clk = ~clk;

    reflet_float_op_driver #(.float_size(16), .latency(LAT2)) u_l2 (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .op_a(op_a), .op_b(op_b), .opr_a(opr_a2), .opr_b(opr_b2),
        .opr_result(opr_result2), .res_valid(res_valid2), .res_ready(res_ready2),
        .result(result2), .busy(busy2)
    );

    reflet_float_op_driver #(.float_size(16), .latency(1)) u_l1 (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .op_a(op_a), .op_b(op_b), .opr_a(opr_a1), .opr_b(opr_b1),
        .opr_result(opr_result1), .res_valid(res_valid1), .res_ready(res_ready1),
        .result(result1), .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1;
        req_valid2 = 1'b0; res_ready2 = 1'b0; req_valid1 = 1'b0; res_ready1 = 1'b0;
        op_a = 16'h1234; op_b = 16'h5678;
        step(); step();
        vectors++; if (res_valid2 !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b want 0", res_valid2); end
        vectors++; if (result2 !== 16'h0) begin miscompares++; $display("FAIL reset_result got %h want 0000", result2); end
        vectors++; if (opr_a2 !== 16'h0 || opr_b2 !== 16'h0) begin miscompares++; $display("FAIL reset_opr got %h/%h want 0000/0000", opr_a2, opr_b2); end
        vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy2); end
        reset = 1'b1;
        step();
        vectors++; if (req_ready2 !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready2); end
    endtask

    task automatic test_basic();
        logic [15:0] a, b, e;
        for (int i = 0; i < 5; i++) begin
            a = (i == 0) ? 16'h3C00 : 16'($urandom);
            b = (i == 0) ? 16'h4000 : 16'($urandom);
            e = f_op(a, b);
            op_a = a; op_b = b; req_valid2 = 1'b1;
            step();
            req_valid2 = 1'b0;
            vectors++; if (busy2 !== 1'b1 || req_ready2 !== 1'b0) begin miscompares++; $display("FAIL basic_accept busy/req_ready got %b/%b want 1/0", busy2, req_ready2); end
            vectors++; if (opr_a2 !== a || opr_b2 !== b) begin miscompares++; $display("FAIL basic_opr got %h/%h want %h/%h", opr_a2, opr_b2, a, b); end
            for (int k = 1; k < LAT2; k++) begin
                step();
                vectors++; if (res_valid2 !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %b want 0", res_valid2); end
            end
            step();
            vectors++; if (res_valid2 !== 1'b1 || busy2 !== 1'b1) begin miscompares++; $display("FAIL basic_capture valid/busy got %b/%b want 1/1", res_valid2, busy2); end
            vectors++; if (result2 !== e) begin miscompares++; $display("FAIL basic_result got %h want %h", result2, e); end
            if (i == 0) begin
                vectors++; if (result2 !== 16'h4200) begin miscompares++; $display("FAIL basic_example got %h want 4200", result2); end
            end
            res_ready2 = 1'b1;
            step();
            res_ready2 = 1'b0;
            vectors++; if (res_valid2 !== 1'b0 || busy2 !== 1'b0 || req_ready2 !== 1'b1) begin miscompares++; $display("FAIL basic_consume valid/busy/ready got %b/%b/%b want 0/0/1", res_valid2, busy2, req_ready2); end
            vectors++; if (result2 !== e) begin miscompares++; $display("FAIL basic_result_kept got %h want %h", result2, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b, e;
        a = 16'($urandom); b = 16'($urandom); e = f_op(a, b);
        op_a = a; op_b = b; req_valid2 = 1'b1;
        step();
        req_valid2 = 1'b0;
        for (int k = 0; k < LAT2; k++) step();
        for (int k = 0; k < 5; k++) begin
            op_a = 16'($urandom); op_b = 16'($urandom);
            step();
            vectors++; if (res_valid2 !== 1'b1 || result2 !== e) begin miscompares++; $display("FAIL bp_hold valid/result got %b/%h want 1/%h", res_valid2, result2, e); end
            vectors++; if (req_ready2 !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready got %b want 0", req_ready2); end
        end
        res_ready2 = 1'b1;
        step();
        res_ready2 = 1'b0;
        vectors++; if (res_valid2 !== 1'b0 || busy2 !== 1'b0) begin miscompares++; $display("FAIL bp_release valid/busy got %b/%b want 0/0", res_valid2, busy2); end
    endtask

    task automatic test_abort();
        logic [15:0] a, b, e, c, d;
        a = 16'($urandom); b = 16'($urandom); e = f_op(a, b);
        op_a = a; op_b = b; req_valid2 = 1'b1;
        step();
        req_valid2 = 1'b0;
        enable = 1'b0;
        step();
        vectors++; if (busy2 !== 1'b0 || res_valid2 !== 1'b0) begin miscompares++; $display("FAIL abort_wait busy/valid got %b/%b want 0/0", busy2, res_valid2); end
        vectors++; if (opr_a2 !== a || opr_b2 !== b) begin miscompares++; $display("FAIL abort_opr_kept got %h/%h want %h/%h", opr_a2, opr_b2, a, b); end
        // Request while disabled must be ignored.
        c = 16'($urandom); d = 16'($urandom);
        op_a = c; op_b = d; req_valid2 = 1'b1;
        vectors++; if (req_ready2 !== 1'b0) begin miscompares++; $display("FAIL abort_req_ready got %b want 0", req_ready2); end
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++; if (res_valid2 !== 1'b0 || busy2 !== 1'b0 || opr_a2 !== a) begin miscompares++; $display("FAIL abort_idle valid/busy/opr_a got %b/%b/%h want 0/0/%h", res_valid2, busy2, opr_a2, a); end
        end
        req_valid2 = 1'b0;
        enable = 1'b1;
        // Fresh request completes normally.
        op_a = c; op_b = d; req_valid2 = 1'b1;
        step();
        req_valid2 = 1'b0;
        for (int k = 0; k < LAT2; k++) step();
        vectors++; if (res_valid2 !== 1'b1 || result2 !== f_op(c, d)) begin miscompares++; $display("FAIL abort_resume valid/result got %b/%h want 1/%h", res_valid2, result2, f_op(c, d)); end
        // Enable low together with res_ready in HOLD: IDLE, result kept.
        enable = 1'b0; res_ready2 = 1'b1;
        step();
        enable = 1'b1; res_ready2 = 1'b0;
        vectors++; if (res_valid2 !== 1'b0 || busy2 !== 1'b0 || result2 !== f_op(c, d)) begin miscompares++; $display("FAIL abort_hold valid/busy/result got %b/%b/%h want 0/0/%h", res_valid2, busy2, result2, f_op(c, d)); end
        vectors++; if (e === f_op(c, d) && res_valid2 !== 1'b0) begin miscompares++; $display("FAIL abort_stale got %b want 0", res_valid2); end
    endtask

    task automatic test_ignore();
        logic [15:0] a1, b1, a2, b2;
        res_ready2 = 1'b1;
        step(); step();
        res_ready2 = 1'b0;
        vectors++; if (busy2 !== 1'b0 || res_valid2 !== 1'b0) begin miscompares++; $display("FAIL ign_idle_ready busy/valid got %b/%b want 0/0", busy2, res_valid2); end
        a1 = 16'($urandom); b1 = 16'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
        op_a = a1; op_b = b1; req_valid2 = 1'b1;
        step();
        op_a = a2; op_b = b2;
        for (int k = 0; k < LAT2; k++) begin
            step();
            vectors++; if (opr_a2 !== a1 || opr_b2 !== b1) begin miscompares++; $display("FAIL ign_wait_opr got %h/%h want %h/%h", opr_a2, opr_b2, a1, b1); end
        end
        vectors++; if (res_valid2 !== 1'b1 || result2 !== f_op(a1, b1)) begin miscompares++; $display("FAIL ign_result valid/result got %b/%h want 1/%h", res_valid2, result2, f_op(a1, b1)); end
        res_ready2 = 1'b1;
        step();
        res_ready2 = 1'b0;
        vectors++; if (busy2 !== 1'b0 || opr_a2 !== a1) begin miscompares++; $display("FAIL ign_consume_edge busy/opr_a got %b/%h want 0/%h", busy2, opr_a2, a1); end
        step();
        req_valid2 = 1'b0;
        vectors++; if (busy2 !== 1'b1 || opr_a2 !== a2 || opr_b2 !== b2) begin miscompares++; $display("FAIL ign_second_load busy/opr got %b/%h/%h want 1/%h/%h", busy2, opr_a2, opr_b2, a2, b2); end
        for (int k = 0; k < LAT2; k++) step();
        vectors++; if (res_valid2 !== 1'b1 || result2 !== f_op(a2, b2)) begin miscompares++; $display("FAIL ign_second_result valid/result got %b/%h want 1/%h", res_valid2, result2, f_op(a2, b2)); end
        res_ready2 = 1'b1;
        step();
        res_ready2 = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [15:0] a, b;
        a = 16'($urandom) | 16'h0001; b = 16'($urandom);
        op_a = a; op_b = b; req_valid2 = 1'b1;
        step();
        req_valid2 = 1'b0;
        for (int k = 0; k < LAT2; k++) step();
        vectors++; if (res_valid2 !== 1'b1) begin miscompares++; $display("FAIL ar_pre_hold got %b want 1", res_valid2); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (res_valid2 !== 1'b0 || result2 !== 16'h0) begin miscompares++; $display("FAIL ar_immediate valid/result got %b/%h want 0/0000", res_valid2, result2); end
        vectors++; if (busy2 !== 1'b0 || opr_a2 !== 16'h0) begin miscompares++; $display("FAIL ar_state busy/opr_a got %b/%h want 0/0000", busy2, opr_a2); end
        step();
        reset = 1'b1;
        vectors++; if (req_ready2 !== 1'b1) begin miscompares++; $display("FAIL ar_req_ready got %b want 1", req_ready2); end
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++; if (res_valid2 !== 1'b0 || busy2 !== 1'b0) begin miscompares++; $display("FAIL ar_after valid/busy got %b/%b want 0/0", res_valid2, busy2); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ra [0:29];
        logic [15:0] rb [0:29];
        logic        expv;
        int          nres;
        nres = 0;
        req_valid1 = 1'b1; res_ready1 = 1'b1;
        for (int e = 0; e < 30; e++) begin
            ra[e] = 16'($urandom); rb[e] = 16'($urandom);
            op_a = ra[e]; op_b = rb[e];
            step();
            // Accept on edges 0,3,6..; capture one edge later; consume next.
            expv = ((e % 3) == 1);
            vectors++; if (res_valid1 !== expv) begin miscompares++; $display("FAIL b2b_valid edge %0d got %b want %b", e, res_valid1, expv); end
            if (expv) begin
                vectors++; if (result1 !== f_op(ra[e-1], rb[e-1])) begin miscompares++; $display("FAIL b2b_result edge %0d got %h want %h", e, result1, f_op(ra[e-1], rb[e-1])); end
            end
            if (res_valid1 === 1'b1) nres++;
        end
        req_valid1 = 1'b0; res_ready1 = 1'b0;
        vectors++; if (nres !== 10) begin miscompares++; $display("FAIL b2b_count got %0d want 10", nres); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_ignore();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
